ramp_profile_ctrl: RTL and testbench

- Sequencer that drives a PWM datapath through a configurable trapezoid profile: rise to a target duty, hold, then fall back to zero.
- Ramp rate, target and hold time are loaded through a valid/ready config port. A start/abort pair controls the run.
- Sits between the system control logic and the PWM output pin. It replaces the fixed free-running ramp with a software-programmable profile.

---
 rtl/ramp_profile_pkg.sv | 27 ++
 rtl/ramp_profile_ctrl_if.sv | 38 +++
 rtl/ramp_profile_ctrl_pwm_compare.sv | 33 +++
 rtl/ramp_profile_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ramp_profile_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ramp_profile_pkg.sv
// ramp_profile_pkg
// Shared definitions for the ramp profile sequencer: the FSM state
// encoding, default parameter values and the helper that sizes the tick
// divider counter from its division ratio.
package ramp_profile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    HOLD,
    FALL,
    DONE
  } state_t;

  localparam int DEF_PWM_BITS  = 10;
  localparam int DEF_TICK_DIV  = 48;
  localparam int DEF_HOLD_BITS = 16;

  // Divider needs to hold values 0..TICK_DIV-1; sizing on TICK_DIV+1 keeps
  // the width at least 1 bit even when TICK_DIV is 1.
  function automatic int div_bits(input int tick_div);
    return $clog2(tick_div + 1);
  endfunction

  localparam int DEF_DIV_BITS = div_bits(DEF_TICK_DIV);

endpackage

// File: rtl/ramp_profile_ctrl_if.sv
// ramp_profile_ctrl_if
// Configuration port of the ramp profile sequencer (valid/ready handshake).
//   cfg_valid  : master offers a new profile
//   cfg_ready  : slave can accept (only while idle)
//   cfg_target : plateau duty
//   cfg_step   : duty change per tick (0 behaves as 1)
//   cfg_hold   : plateau length in ticks
// master = system control logic, slave = ramp_profile_ctrl.
interface ramp_profile_ctrl_if
  import ramp_profile_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int HOLD_BITS = DEF_HOLD_BITS
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [PWM_BITS-1:0]  cfg_target;
  logic [PWM_BITS-1:0]  cfg_step;
  logic [HOLD_BITS-1:0] cfg_hold;

  modport master (
    output cfg_valid,
    output cfg_target,
    output cfg_step,
    output cfg_hold,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_target,
    input  cfg_step,
    input  cfg_hold,
    output cfg_ready
  );

endinterface

// File: rtl/ramp_profile_ctrl_pwm_compare.sv
// pwm_compare
// Free-running PWM counter with a registered comparator.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   duty    : compare value, high time per period in clk cycles
//   pwm_out : registered PWM output, one cycle behind duty
// The counter is never gated, so the PWM phase is independent of the
// sequencer state. Since the compare is strict, duty=0 is constant low and
// the largest duty leaves one low cycle per period.
module pwm_compare
  import ramp_profile_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/ramp_profile_ctrl.sv
// ramp_profile_ctrl
// Sequences a PWM datapath through a trapezoid profile: ramp up to a target
// duty, hold for a number of ticks, ramp back down to zero.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   cfg     : config handshake (slave modport), accepted only in IDLE
//   start   : level-sampled launch from IDLE
//   abort   : immediate shutdown from RISE/HOLD/FALL
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse in the DONE state
//   aborted : qualifies done when the run was cut short by abort
//   duty    : current duty value (registered)
//   pwm_out : registered PWM output
module ramp_profile_ctrl
  import ramp_profile_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int HOLD_BITS = DEF_HOLD_BITS
) (
  input  logic                clk,
  input  logic                rst,
  ramp_profile_ctrl_if.slave  cfg,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam int DIV_BITS = div_bits(TICK_DIV);
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(TICK_DIV - 1);

  state_t               state;
  logic [PWM_BITS-1:0]  target_q;
  logic [PWM_BITS-1:0]  step_q;
  logic [HOLD_BITS-1:0] hold_q;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic [DIV_BITS-1:0]  div_cnt;

  logic                 tick;
  logic [PWM_BITS-1:0]  step_eff;
  logic [PWM_BITS:0]    rise_sum;
  logic [PWM_BITS-1:0]  rise_next;
  logic [PWM_BITS-1:0]  fall_next;
  logic                 hold_last;

  // Config is only taken while idle so a running profile never sees its
  // parameters change underneath it.
  assign cfg.cfg_ready = (state == IDLE);

  assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
  assign step_eff = (step_q == '0) ? PWM_BITS'(1) : step_q;

  // Rise is summed one bit wider so a large step clamps to the target
  // instead of wrapping past it.
  assign rise_sum  = {1'b0, duty} + {1'b0, step_eff};
  assign rise_next = (rise_sum >= {1'b0, target_q}) ? target_q : rise_sum[PWM_BITS-1:0];
  assign fall_next = (duty > step_eff) ? (duty - step_eff) : '0;
  assign hold_last = (({1'b0, hold_cnt} + 1'b1) == {1'b0, hold_q});

  // Divider, hold counter, config shadows and the profile FSM. Abort is
  // checked ahead of tick handling in every active state, so it wins when
  // both land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      target_q <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          done     <= 1'b0;
          aborted  <= 1'b0;
          hold_cnt <= '0;
          if (cfg.cfg_valid) begin
            target_q <= cfg.cfg_target;
            step_q   <= cfg.cfg_step;
            hold_q   <= cfg.cfg_hold;
          end
          if (start) begin
            state <= RISE;
            busy  <= 1'b1;
          end
        end

        RISE: begin
          if (abort) begin
            duty    <= '0;
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (duty == target_q) begin
            state <= HOLD;
          end else if (tick) begin
            duty <= rise_next;
            if (rise_next == target_q) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (abort) begin
            duty    <= '0;
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (hold_q == '0) begin
            state <= FALL;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_last) begin
              state <= FALL;
            end
          end
        end

        FALL: begin
          if (abort) begin
            duty    <= '0;
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (duty == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (tick) begin
            duty <= fall_next;
            if (fall_next == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          aborted <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          duty    <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          aborted <= 1'b0;
        end
      endcase
    end
  end

  pwm_compare #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_ramp_profile_ctrl.sv
// tb_ramp_profile_ctrl
// Directed bench for ramp_profile_ctrl with PWM_BITS=4, TICK_DIV=4,
// HOLD_BITS=4. Expected duty steps, busy lengths and done/aborted pulses
// are queued when a profile is launched and consumed by a monitor that
// runs on the falling edge.
module tb_ramp_profile_ctrl;

  localparam int PWM_BITS  = 4;
  localparam int TICK_DIV  = 4;
  localparam int HOLD_BITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PWM_BITS-1:0] exp_duty_q[$];
  int                  exp_busy_q[$];
  logic                exp_done_q[$];

  logic                mon_en = 1'b0;
  logic [PWM_BITS-1:0] prev_duty;
  int                  busy_run = 0;

  ramp_profile_ctrl_if #(.PWM_BITS(PWM_BITS), .HOLD_BITS(HOLD_BITS)) cfg_bus ();

  ramp_profile_ctrl #(
    .PWM_BITS  (PWM_BITS),
    .TICK_DIV  (TICK_DIV),
    .HOLD_BITS (HOLD_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_bus),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of config/start, then release both.
  task automatic applyStimulus(input logic valid, input int target, input int step,
                               input int hold, input logic st);
    cfg_bus.cfg_valid  = valid;
    cfg_bus.cfg_target = PWM_BITS'(target);
    cfg_bus.cfg_step   = PWM_BITS'(step);
    cfg_bus.cfg_hold   = HOLD_BITS'(hold);
    start              = st;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    start             = 1'b0;
  endtask

  // Reference trapezoid for a non-degenerate profile: every rise, hold and
  // fall step costs one tick of TICK_DIV cycles, plus the DONE cycle.
  task automatic pushProfile(input int target, input int step, input int hold);
    int d;
    int s;
    int ticks;
    logic [31:0] dv;
    d     = 0;
    s     = (step == 0) ? 1 : step;
    ticks = 0;
    while (d < target) begin
      d  = (d + s > target) ? target : d + s;
      dv = d;
      exp_duty_q.push_back(dv[PWM_BITS-1:0]);
      ticks++;
    end
    while (d > 0) begin
      d  = (d > s) ? d - s : 0;
      dv = d;
      exp_duty_q.push_back(dv[PWM_BITS-1:0]);
      ticks++;
    end
    ticks += hold;
    exp_busy_q.push_back(TICK_DIV * ticks + 1);
    exp_done_q.push_back(1'b0);
  endtask

  task automatic waitIdle(input int limit);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  // Scoreboard monitor: consumes queued duty steps, busy lengths and done
  // qualifiers as the DUT produces them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (duty !== prev_duty) begin
        if (exp_duty_q.size() == 0) checkOutput("duty_unexpected", duty, prev_duty);
        else checkOutput("duty_step", duty, exp_duty_q.pop_front());
      end
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) checkOutput("done_unexpected", done, 0);
        else checkOutput("aborted_at_done", aborted, exp_done_q.pop_front());
      end else if (aborted !== 1'b0) begin
        checkOutput("aborted_no_done", aborted, 0);
      end
      if (busy === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (exp_busy_q.size() == 0) checkOutput("busy_unexpected", busy_run, 0);
        else checkOutput("busy_len", busy_run, exp_busy_q.pop_front());
        busy_run = 0;
      end
    end
    prev_duty = duty;
  end

  initial begin
    int highs;
    rst                = 1'b1;
    start              = 1'b0;
    abort              = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_target = '0;
    cfg_bus.cfg_step   = '0;
    cfg_bus.cfg_hold   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_duty", duty, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_pwm", pwm_out, 0);
    checkOutput("rst_ready", cfg_bus.cfg_ready, 1);
    mon_en = 1'b1;

    $display("[TB] basic profile 12/4/2 with config offered while busy");
    applyStimulus(1'b1, 12, 4, 2, 1'b0);
    checkOutput("ready_idle", cfg_bus.cfg_ready, 1);
    pushProfile(12, 4, 2);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("ready_in_rise", cfg_bus.cfg_ready, 0);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_target = 4'd3;
    cfg_bus.cfg_step   = 4'd1;
    cfg_bus.cfg_hold   = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("ready_busy", cfg_bus.cfg_ready, 0);
    cfg_bus.cfg_valid = 1'b0;
    waitIdle(60);
    checkOutput("basic_ready_end", cfg_bus.cfg_ready, 1);
    checkOutput("basic_duty_end", duty, 0);

    $display("[TB] saturation 10/4/1, config together with start");
    pushProfile(10, 4, 1);
    applyStimulus(1'b1, 10, 4, 1, 1'b1);
    waitIdle(60);

    $display("[TB] degenerate 0/0/0");
    applyStimulus(1'b1, 0, 0, 0, 1'b0);
    exp_busy_q.push_back(4);
    exp_done_q.push_back(1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    checkOutput("degen_done_e1", done, 0);
    repeat (2) @(negedge clk);
    checkOutput("degen_done_e3", done, 0);
    checkOutput("degen_pwm_e3", pwm_out, 0);
    @(negedge clk);
    checkOutput("degen_done_e4", done, 1);
    checkOutput("degen_duty_e4", duty, 0);
    checkOutput("degen_pwm_e4", pwm_out, 0);
    waitIdle(10);

    $display("[TB] abort in HOLD on a tick");
    exp_duty_q.push_back(4'd4);
    exp_duty_q.push_back(4'd8);
    exp_duty_q.push_back(4'd12);
    exp_duty_q.push_back(4'd0);
    exp_busy_q.push_back(17);
    exp_done_q.push_back(1'b1);
    applyStimulus(1'b1, 12, 4, 3, 1'b1);
    repeat (15) @(negedge clk);
    checkOutput("abort_pre_duty", duty, 12);
    checkOutput("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_duty", duty, 0);
    checkOutput("abort_done", done, 1);
    checkOutput("abort_flag", aborted, 1);
    @(negedge clk);
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_idle_ready", cfg_bus.cfg_ready, 1);
    checkOutput("abort_idle_done", done, 0);

    $display("[TB] PWM at duty 5");
    pushProfile(5, 5, 15);
    applyStimulus(1'b1, 5, 5, 15, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("pwm_duty", duty, 5);
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    checkOutput("pwm_high_32", highs, 10);
    waitIdle(100);

    $display("[TB] reset mid-RISE");
    exp_duty_q.push_back(4'd4);
    exp_duty_q.push_back(4'd0);
    exp_busy_q.push_back(6);
    applyStimulus(1'b1, 12, 4, 2, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("rise_duty_pre_rst", duty, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_duty", duty, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_pwm", pwm_out, 0);
    checkOutput("mid_rst_ready", cfg_bus.cfg_ready, 1);

    $display("[TB] start after reset uses cleared shadows");
    exp_busy_q.push_back(4);
    exp_done_q.push_back(1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    waitIdle(10);
    checkOutput("cleared_duty", duty, 0);

    @(negedge clk);
    checkOutput("duty_q_left", exp_duty_q.size(), 0);
    checkOutput("busy_q_left", exp_busy_q.size(), 0);
    checkOutput("done_q_left", exp_done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
